// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch controller.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2,
    DROP = 2'd3
  } fetch_state_e;

  typedef enum logic [1:0] {
    PC_HOLD = 2'd0,
    PC_NEXT = 2'd1,
    PC_LOAD = 2'd2
  } pc_op_e;

  localparam int unsigned PC_INC   = 4;
  localparam int unsigned PC_RESET = 0;

endpackage

// File: rtl/pc_reg.sv
// Program counter register with hold / increment / redirect selection.
module pc_reg
  import fetch_pkg::*;
#(
  parameter int PC_W = 9
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [1:0]      op,
  input  logic [PC_W-1:0] target,
  output logic [PC_W-1:0] pc
);

  // Increment wraps naturally modulo 2^PC_W.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= PC_W'(PC_RESET);
    end else begin
      case (pc_op_e'(op))
        PC_NEXT: pc <= pc + PC_W'(PC_INC);
        PC_LOAD: pc <= target;
        default: pc <= pc;
      endcase
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: sequential fetch, stall hold, branch redirect with in-flight drop.
// Define FETCH_MISALIGN_TRAP_EN to trap on misaligned redirect targets instead of forcing alignment.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int PC_W = 9
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            PcSel,
  input  logic [31:0]     BrPC,
  input  logic            Stall,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic            if_valid,
  output logic [PC_W-1:0] if_pc,
  output logic [31:0]     if_instr,
  output logic            Flush,
  output logic            misalign_trap
);

  fetch_state_e    state_q, state_d;
  pc_op_e          pc_op;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] target;
  logic [PC_W-1:0] drop_addr_q;
  logic            redirect;
  logic            trap_req;
  logic            capture;
  logic            clear_valid;
  logic            drop_load;
  logic            unused_brpc;

  assign unused_brpc = ^{BrPC[31:PC_W], BrPC[1:0]};

`ifdef FETCH_MISALIGN_TRAP_EN
  logic trap_q;

  // A misaligned target is refused outright; fetch carries on as if no branch came.
  assign redirect = PcSel && (BrPC[1:0] == 2'b00);
  assign trap_req = PcSel && (BrPC[1:0] != 2'b00);
  assign target   = BrPC[PC_W-1:0];

  always_ff @(posedge clk) begin
    if (reset) trap_q <= 1'b0;
    else       trap_q <= trap_req;
  end

  assign misalign_trap = trap_q;
`else
  assign redirect      = PcSel;
  assign trap_req      = 1'b0;
  assign target        = {BrPC[PC_W-1:2], 2'b00};
  assign misalign_trap = 1'b0;
`endif

  pc_reg #(
    .PC_W(PC_W)
  ) u_pc_reg (
    .clk   (clk),
    .reset (reset),
    .op    (pc_op),
    .target(target),
    .pc    (pc)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    pc_op       = PC_HOLD;
    capture     = 1'b0;
    clear_valid = 1'b0;
    drop_load   = 1'b0;
    case (state_q)
      IDLE: begin
        clear_valid = 1'b1;
        state_d     = REQ;
        if (redirect) pc_op = PC_LOAD;
      end
      REQ: begin
        if (redirect) begin
          pc_op       = PC_LOAD;
          clear_valid = 1'b1;
          if (imem_ack) begin
            state_d = REQ;
          end else begin
            state_d   = DROP;
            drop_load = 1'b1;
          end
        end else if (imem_ack) begin
          capture = 1'b1;
          if (Stall) state_d = HOLD;
          else       pc_op   = PC_NEXT;
        end else begin
          clear_valid = 1'b1;
        end
      end
      HOLD: begin
        if (redirect) begin
          pc_op       = PC_LOAD;
          clear_valid = 1'b1;
          state_d     = REQ;
        end else if (!Stall) begin
          pc_op       = PC_NEXT;
          clear_valid = 1'b1;
          state_d     = REQ;
        end
      end
      DROP: begin
        // The bus read must complete at its original address; only the PC moves.
        clear_valid = 1'b1;
        if (redirect) pc_op = PC_LOAD;
        if (imem_ack) state_d = REQ;
      end
      default: state_d = IDLE;
    endcase
  end

  assign imem_req  = (state_q == REQ) || (state_q == DROP);
  assign imem_addr = (state_q == DROP) ? drop_addr_q : pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      if_valid    <= 1'b0;
      if_pc       <= '0;
      if_instr    <= '0;
      Flush       <= 1'b0;
      drop_addr_q <= '0;
    end else begin
      if (capture) begin
        if_valid <= 1'b1;
        if_pc    <= pc;
        if_instr <= imem_rdata;
      end else if (clear_valid) begin
        if_valid <= 1'b0;
      end
      if (drop_load) drop_addr_q <= pc;
      Flush <= redirect;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed self-checking bench for fetch_ctrl (PC_W = 9).
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        PcSel;
  logic [31:0] BrPC;
  logic        Stall;
  logic        imem_req;
  logic [8:0]  imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [8:0]  if_pc;
  logic [31:0] if_instr;
  logic        Flush;
  logic        misalign_trap;

  int errors = 0;
  int checks = 0;

  fetch_ctrl #(.PC_W(9)) dut (
    .clk          (clk),
    .reset        (reset),
    .PcSel        (PcSel),
    .BrPC         (BrPC),
    .Stall        (Stall),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .if_valid     (if_valid),
    .if_pc        (if_pc),
    .if_instr     (if_instr),
    .Flush        (Flush),
    .misalign_trap(misalign_trap)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [8:0] a);
    return 32'hC0DE_0000 | {23'd0, a};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    reset = 1'b1; PcSel = 1'b0; BrPC = '0; Stall = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
    step(); step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1; PcSel = 1'b0; BrPC = '0; Stall = 1'b0;
    imem_ack = 1'b1; imem_rdata = 32'hFFFF_FFFF;
    step(); step();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_req: got %b want 0", imem_req); end
    checks++; if (if_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b want 0", if_valid); end
    checks++; if (Flush !== 1'b0 || misalign_trap !== 1'b0) begin errors++; $display("[TB] FAIL reset_pulses: got %b%b want 00", Flush, misalign_trap); end
    checks++; if (if_pc !== 9'h000 || if_instr !== 32'h0) begin errors++; $display("[TB] FAIL reset_capture: got %h/%h want 000/00000000", if_pc, if_instr); end
    reset = 1'b0;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL idle_req: got %b want 0", imem_req); end
    step();
    imem_ack = 1'b0;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 9'h000) begin errors++; $display("[TB] FAIL first_req: got %b/%h want 1/000", imem_req, imem_addr); end
    checks++; if (if_valid !== 1'b0 || if_instr !== 32'h0) begin errors++; $display("[TB] FAIL idle_ack_ignored: got %b/%h want 0/00000000", if_valid, if_instr); end
  endtask

  task automatic test_sequential();
    for (int k = 0; k < 4; k++) begin
      logic [8:0] a;
      a = 9'(k * 4);
      checks++; if (imem_req !== 1'b1 || imem_addr !== a) begin errors++; $display("[TB] FAIL seq_addr%0d: got %b/%h want 1/%h", k, imem_req, imem_addr, a); end
      imem_ack = 1'b1; imem_rdata = mem_word(a);
      step();
      checks++; if (if_valid !== 1'b1 || if_pc !== a || if_instr !== mem_word(a)) begin errors++; $display("[TB] FAIL seq_capture%0d: got %b/%h/%h want 1/%h/%h", k, if_valid, if_pc, if_instr, a, mem_word(a)); end
      checks++; if (Flush !== 1'b0) begin errors++; $display("[TB] FAIL seq_flush%0d: got %b want 0", k, Flush); end
    end
    imem_ack = 1'b0;
  endtask

  task automatic test_stall();
    checks++; if (imem_addr !== 9'h010) begin errors++; $display("[TB] FAIL stall_pre_addr: got %h want 010", imem_addr); end
    imem_ack = 1'b1; imem_rdata = mem_word(9'h010); Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      imem_ack = 1'b0;
      checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL stall_req%0d: got %b want 0", i, imem_req); end
      checks++; if (if_valid !== 1'b1 || if_pc !== 9'h010 || if_instr !== mem_word(9'h010)) begin errors++; $display("[TB] FAIL stall_hold%0d: got %b/%h/%h want 1/010/%h", i, if_valid, if_pc, if_instr, mem_word(9'h010)); end
    end
    Stall = 1'b0;
    step();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 9'h014) begin errors++; $display("[TB] FAIL stall_resume: got %b/%h want 1/014", imem_req, imem_addr); end
    checks++; if (if_valid !== 1'b0) begin errors++; $display("[TB] FAIL stall_valid_clear: got %b want 0", if_valid); end
  endtask

  task automatic test_drop();
    reset_dut();
    imem_ack = 1'b1; imem_rdata = mem_word(9'h000); step();
    imem_rdata = mem_word(9'h004); step();
    imem_ack = 1'b0; step();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 9'h008) begin errors++; $display("[TB] FAIL drop_pending: got %b/%h want 1/008", imem_req, imem_addr); end
    PcSel = 1'b1; BrPC = 32'h40;
    step();
    PcSel = 1'b0;
    checks++; if (Flush !== 1'b1) begin errors++; $display("[TB] FAIL drop_flush: got %b want 1", Flush); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 9'h008 || if_valid !== 1'b0) begin errors++; $display("[TB] FAIL drop_hold_addr: got %b/%h/%b want 1/008/0", imem_req, imem_addr, if_valid); end
    step();
    checks++; if (Flush !== 1'b0 || imem_addr !== 9'h008) begin errors++; $display("[TB] FAIL drop_wait: got %b/%h want 0/008", Flush, imem_addr); end
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    step();
    imem_ack = 1'b0;
    checks++; if (imem_addr !== 9'h040 || if_valid !== 1'b0 || Flush !== 1'b0) begin errors++; $display("[TB] FAIL drop_retire: got %h/%b/%b want 040/0/0", imem_addr, if_valid, Flush); end
    step();
    PcSel = 1'b1; BrPC = 32'h60; step();
    BrPC = 32'h70; step();
    checks++; if (imem_addr !== 9'h040 || Flush !== 1'b1) begin errors++; $display("[TB] FAIL retarget_hold: got %h/%b want 040/1", imem_addr, Flush); end
    PcSel = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    step();
    imem_ack = 1'b0;
    checks++; if (imem_addr !== 9'h070 || if_valid !== 1'b0) begin errors++; $display("[TB] FAIL retarget_last_wins: got %h/%b want 070/0", imem_addr, if_valid); end
  endtask

  task automatic test_redirect_ack();
    imem_ack = 1'b1; imem_rdata = 32'h0BAD_0BAD; PcSel = 1'b1; BrPC = 32'h20;
    step();
    imem_ack = 1'b0; PcSel = 1'b0;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 9'h020) begin errors++; $display("[TB] FAIL redir_ack_addr: got %b/%h want 1/020", imem_req, imem_addr); end
    checks++; if (if_valid !== 1'b0 || Flush !== 1'b1) begin errors++; $display("[TB] FAIL redir_ack_discard: got %b/%b want 0/1", if_valid, Flush); end
  endtask

  task automatic test_stall_redirect();
    imem_ack = 1'b1; imem_rdata = mem_word(9'h020); Stall = 1'b1;
    step();
    imem_ack = 1'b0;
    checks++; if (imem_req !== 1'b0 || if_pc !== 9'h020) begin errors++; $display("[TB] FAIL sr_hold: got %b/%h want 0/020", imem_req, if_pc); end
    PcSel = 1'b1; BrPC = 32'h80;
    step();
    PcSel = 1'b0; Stall = 1'b0;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 9'h080) begin errors++; $display("[TB] FAIL sr_addr: got %b/%h want 1/080", imem_req, imem_addr); end
    checks++; if (Flush !== 1'b1 || if_valid !== 1'b0) begin errors++; $display("[TB] FAIL sr_flush: got %b/%b want 1/0", Flush, if_valid); end
    step();
    checks++; if (Flush !== 1'b0 || imem_addr !== 9'h080) begin errors++; $display("[TB] FAIL sr_flush_once: got %b/%h want 0/080", Flush, imem_addr); end
  endtask

  task automatic test_wrap();
    imem_ack = 1'b1; imem_rdata = 32'h0; PcSel = 1'b1; BrPC = 32'h1FC;
    step();
    PcSel = 1'b0;
    checks++; if (imem_addr !== 9'h1FC) begin errors++; $display("[TB] FAIL wrap_target: got %h want 1fc", imem_addr); end
    imem_rdata = mem_word(9'h1FC);
    step();
    imem_ack = 1'b0;
    checks++; if (imem_addr !== 9'h000) begin errors++; $display("[TB] FAIL wrap_addr: got %h want 000", imem_addr); end
    checks++; if (if_valid !== 1'b1 || if_pc !== 9'h1FC) begin errors++; $display("[TB] FAIL wrap_capture: got %b/%h want 1/1fc", if_valid, if_pc); end
  endtask

  task automatic test_misalign();
    imem_ack = 1'b1; imem_rdata = mem_word(9'h000); PcSel = 1'b1; BrPC = 32'h42;
    step();
    imem_ack = 1'b0; PcSel = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    checks++; if (misalign_trap !== 1'b1 || Flush !== 1'b0) begin errors++; $display("[TB] FAIL mis_trap: got %b/%b want 1/0", misalign_trap, Flush); end
    checks++; if (imem_addr !== 9'h004 || if_valid !== 1'b1 || if_pc !== 9'h000) begin errors++; $display("[TB] FAIL mis_seq: got %h/%b/%h want 004/1/000", imem_addr, if_valid, if_pc); end
    step();
    checks++; if (misalign_trap !== 1'b0) begin errors++; $display("[TB] FAIL mis_trap_once: got %b want 0", misalign_trap); end
`else
    checks++; if (misalign_trap !== 1'b0 || Flush !== 1'b1) begin errors++; $display("[TB] FAIL mis_flush: got %b/%b want 0/1", misalign_trap, Flush); end
    checks++; if (imem_addr !== 9'h040 || if_valid !== 1'b0) begin errors++; $display("[TB] FAIL mis_align: got %h/%b want 040/0", imem_addr, if_valid); end
    step();
    checks++; if (misalign_trap !== 1'b0 || Flush !== 1'b0) begin errors++; $display("[TB] FAIL mis_quiet: got %b/%b want 0/0", misalign_trap, Flush); end
`endif
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_drop();
    test_redirect_ack();
    test_stall_redirect();
    test_wrap();
    test_misalign();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter PC_W, default 9, width of the program counter and instruction-memory address.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 PcSel  input  1  branch-taken redirect request from the execute stage.
REQ-005 BrPC  input  32  redirect target; only bits [PC_W-1:0] are used.
REQ-006 Stall  input  1  hazard-unit stall; holds the fetched instruction.
REQ-007 imem_req  output  1  instruction-memory read request.
REQ-008 imem_addr  output  PC_W  byte address of the read.
REQ-009 imem_ack  input  1  memory completes the read this cycle; imem_rdata is valid.
REQ-010 imem_rdata  input  32  instruction word.
REQ-011 if_valid  output  1  if_instr/if_pc hold a live instruction for IF/ID.
REQ-012 if_pc  output  PC_W  address of if_instr.
REQ-013 if_instr  output  32  fetched instruction.
REQ-014 Flush  output  1  one-cycle kill of IF/ID and ID/EX contents.
REQ-015 misalign_trap  output  1  one-cycle misaligned-target pulse.

Function
REQ-016 States SHALL be IDLE, REQ, HOLD, DROP; the PC register is internal, PC_W bits.
REQ-017 IDLE SHALL last exactly one cycle after reset, then go to REQ.
REQ-018 REQ SHALL drive imem_req=1 and imem_addr=PC; imem_addr SHALL stay stable while imem_req=1 and imem_ack=0.
REQ-019 REQ with imem_ack and no PcSel SHALL register if_instr=imem_rdata, if_pc=PC, and if_valid=1 the next cycle.
REQ-020 In that case, Stall=0 SHALL set PC<=PC+4 and stay in REQ, giving back-to-back fetch at one instruction per ack.
REQ-021 In that case, Stall=1 SHALL go to HOLD with PC unchanged.
REQ-022 HOLD SHALL keep imem_req=0 and if_valid/if_instr/if_pc frozen.
REQ-023 HOLD with Stall=0 SHALL set PC<=PC+4, if_valid<=0, and go to REQ.
REQ-024 if_valid SHALL be 0 in any cycle without a freshly captured or held instruction.
REQ-025 PcSel=1 SHALL take priority over Stall in every state: PC<=BrPC[PC_W-1:0], if_valid<=0, and Flush=1 for exactly the following cycle.
REQ-026 PcSel in REQ with imem_ack=0 SHALL go to DROP.
REQ-027 DROP SHALL keep imem_req=1 with the old address until imem_ack, discard the data, then go to REQ at the new PC.
REQ-028 PcSel coincident with imem_ack SHALL discard imem_rdata and go to REQ at the new PC.
REQ-029 PcSel in DROP SHALL overwrite the pending target; the last target wins.
REQ-030 PC arithmetic SHALL wrap modulo 2^PC_W; PC = 2^PC_W-4 increments to 0.
REQ-031 Flush SHALL never assert except the cycle after an accepted redirect.

Reset
REQ-032 reset=1 SHALL force state=IDLE and PC=0.
REQ-033 reset=1 SHALL force imem_req, if_valid, Flush, and misalign_trap to 0, and if_pc and if_instr to 0.
REQ-034 reset asserted mid-request SHALL abandon the outstanding read; an imem_ack arriving during IDLE SHALL be ignored.

Configuration
REQ-035 With FETCH_MISALIGN_TRAP_EN defined, PcSel with BrPC[1:0]!=00 SHALL NOT redirect; misalign_trap SHALL pulse for one cycle; Flush SHALL stay 0; fetch SHALL continue sequentially.
REQ-036 Without FETCH_MISALIGN_TRAP_EN, BrPC[1:0] SHALL be forced to 00 on redirect, and misalign_trap SHALL be tied 0 while the port remains present.

Structure
REQ-037 Package fetch_pkg SHALL hold the state enum (IDLE/REQ/HOLD/DROP), the PC increment constant 4, and the reset PC constant 0.
REQ-038 Sub-module pc_reg SHALL hold the PC register with next-PC selection (hold / +4 / redirect).
REQ-039 The state machine, capture registers, and Flush/trap pulses SHALL remain in fetch_ctrl.

Verification
REQ-040 Reset release, ack every cycle -> imem_addr 0,4,8,C on consecutive REQ cycles; if_pc follows one cycle later.
REQ-041 Stall=1 for 3 cycles after fetch at PC 0x10 -> if_pc=0x10 held, imem_req=0; next request at 0x14.
REQ-042 PcSel with BrPC=0x40 while a read of 0x08 is outstanding and the ack comes 2 cycles later -> data dropped, one Flush pulse, next imem_addr=0x40.
REQ-043 PcSel together with Stall=1, BrPC=0x80 -> redirect wins, Flush pulse, next fetch at 0x80.
REQ-044 PC=0x1FC with PC_W=9 and ack -> next imem_addr=0x000.
REQ-045 BrPC=0x42 with the macro defined -> misalign_trap pulse, no Flush, sequential fetch; without the macro -> redirect to 0x40.
